// File: rtl/ps2_pkg.sv
// Shared types for the multi-channel PS/2 receiver: frame status codes,
// per-channel receive FSM states and the FIFO entry layout.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_PAR  = 2'b01,
        ST_STOP = 2'b10,
        ST_TMO  = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Wide enough for up to 8 channels; the top trims it to its port width.
    localparam int CHAN_W = 3;

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        status_e           status;
        logic [7:0]        data;
    } entry_t;

endpackage

// File: rtl/ps2_rx_chan.sv
// One PS/2 receive channel: 2-flop sync, glitch filter, falling-edge detect,
// frame FSM and inter-bit timeout.
// Ports: clk/reset; ps2_clk/ps2_data raw lines in; done pulses for one cycle
// with data/status of the finished (or aborted) frame.
module ps2_rx_chan
    import ps2_pkg::*;
#(
    parameter int FILT_LEN = 4,
    parameter int TIMEOUT  = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       done,
    output logic [7:0] data,
    output status_e    status
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic [3:0]    clk_cnt;
    logic [3:0]    dat_cnt;
    logic          clk_filt;
    logic          dat_filt;
    logic          clk_filt_q;
    logic          fall;
    logic          tmo_hit;
    rx_state_e     state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tmo_cnt;

    // A level change is accepted only after FILT_LEN consecutive differing
    // samples; any sample equal to the current level restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_cnt    <= '0;
            dat_cnt    <= '0;
            clk_filt   <= 1'b1;
            dat_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_data};
            clk_filt_q <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                clk_cnt <= '0;
            end else if (clk_cnt == 4'(FILT_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                clk_cnt  <= '0;
            end else begin
                clk_cnt <= clk_cnt + 4'd1;
            end
            if (dat_sync[1] == dat_filt) begin
                dat_cnt <= '0;
            end else if (dat_cnt == 4'(FILT_LEN - 1)) begin
                dat_filt <= dat_sync[1];
                dat_cnt  <= '0;
            end else begin
                dat_cnt <= dat_cnt + 4'd1;
            end
        end
    end

    assign fall    = clk_filt_q & ~clk_filt;
    assign tmo_hit = (state != RX_IDLE) && !fall &&
                     (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RX_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (state == RX_IDLE || fall || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_hit) begin
                state <= RX_IDLE;
            end else if (fall) begin
                unique case (state)
                    RX_IDLE: begin
                        if (!dat_filt) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        shreg   <= {dat_filt, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par   <= dat_filt;
                        state <= RX_STOP;
                    end
                    RX_STOP: state <= RX_IDLE;
                endcase
            end
        end
    end

    // done is decoded in the edge cycle so the holding register can
    // capture the frame at the very next clock.
    always_comb begin
        done   = 1'b0;
        data   = shreg;
        status = ST_OK;
        if (tmo_hit) begin
            done   = 1'b1;
            data   = 8'h00;
            status = ST_TMO;
        end else if (fall && state == RX_STOP) begin
            done = 1'b1;
            if (!dat_filt) begin
                status = ST_STOP;
            end else if (^{shreg, par} == 1'b0) begin
                status = ST_PAR;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_multi.sv
// Multi-channel PS/2 receiver: per-channel receivers, one holding register
// per channel, round-robin arbiter and a shared output FIFO.
// Ports: clk/reset; ps2_clk/ps2_data raw lines; out_valid/out_ready with
// out_data/out_status/out_chan head entry; fifo_level; sticky overrun with
// per-bit overrun_clr pulse.
module ps2_rx_multi
    import ps2_pkg::*;
#(
    parameter int  NUM_CH     = 2,
    parameter int  FILT_LEN   = 4,
    parameter int  TIMEOUT    = 2000,
    parameter int  FIFO_DEPTH = 8,
    localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ps2_clk,
    input  logic [NUM_CH-1:0] ps2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [1:0]        out_status,
    output logic [CW-1:0]     out_chan,
    output logic [LW-1:0]     fifo_level,
    output logic [NUM_CH-1:0] overrun,
    input  logic [NUM_CH-1:0] overrun_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_CH-1:0] ch_done;
    logic [7:0]        ch_data   [NUM_CH];
    status_e           ch_status [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ps2_rx_chan #(
            .FILT_LEN (FILT_LEN),
            .TIMEOUT  (TIMEOUT)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .ps2_clk  (ps2_clk[g]),
            .ps2_data (ps2_data[g]),
            .done     (ch_done[g]),
            .data     (ch_data[g]),
            .status   (ch_status[g])
        );
    end

    logic [NUM_CH-1:0] hold_vld;
    entry_t            hold [NUM_CH];
    logic [CW-1:0]     last_gnt;
    logic              gnt_vld;
    logic [CW-1:0]     gnt_idx;
    logic              push;
    logic              pop;
    entry_t            mem [FIFO_DEPTH];
    entry_t            head;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;

    // Search starts at the channel after the last one granted.
    always_comb begin
        int c;
        c       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            c = int'(last_gnt) + i;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (!gnt_vld && hold_vld[c]) begin
                gnt_vld = 1'b1;
                gnt_idx = CW'(c);
            end
        end
    end

    assign pop  = out_valid && out_ready;
    assign push = gnt_vld && ((count != LW'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_vld <= '0;
            overrun  <= '0;
            last_gnt <= CW'(NUM_CH - 1);
            for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
        end else begin
            if (push) last_gnt <= gnt_idx;
            for (int i = 0; i < NUM_CH; i++) begin
                if (push && gnt_idx == CW'(i)) hold_vld[i] <= 1'b0;
                if (ch_done[i] && !hold_vld[i]) begin
                    hold_vld[i] <= 1'b1;
                    hold[i]     <= '{chan:   CHAN_W'(i),
                                     status: ch_status[i],
                                     data:   ch_data[i]};
                end
                // A drop in the same cycle as a clear keeps the flag set.
                if (ch_done[i] && hold_vld[i]) begin
                    overrun[i] <= 1'b1;
                end else if (overrun_clr[i]) begin
                    overrun[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= hold[gnt_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Outputs read as zero while empty so stale storage never shows.
    assign head       = mem[rd_ptr];
    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? head.data : 8'h00;
    assign out_status = out_valid ? head.status : 2'b00;
    assign out_chan   = out_valid ? CW'(head.chan) : '0;
    assign fifo_level = count;

endmodule

// File: tb/tb_ps2_rx_multi.sv
// Directed self-checking bench for ps2_rx_multi (2 channels, FILT_LEN 4,
// TIMEOUT 2000, FIFO_DEPTH 8).
module tb_ps2_rx_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ps2_clk;
    logic [1:0] ps2_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_status;
    logic [0:0] out_chan;
    logic [3:0] fifo_level;
    logic [1:0] overrun;
    logic [1:0] overrun_clr;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   fall_cyc = 0;
    int   valid_cyc = 0;
    logic ov_q = 1'b0;

    always #5 clk = ~clk;

    ps2_rx_multi #(
        .NUM_CH     (2),
        .FILT_LEN   (4),
        .TIMEOUT    (2000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_status  (out_status),
        .out_chan    (out_chan),
        .fifo_level  (fifo_level),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ov_q <= out_valid;
        if (out_valid && !ov_q) valid_cyc <= cyc;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b,
                                          input logic bad_par,
                                          input logic stop);
        return {stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] mask, input logic [10:0] f0,
                        input logic [10:0] f1, input int nbits,
                        input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            cyc_step();
            if (mask[0]) ps2_data[0] = f0[i];
            if (mask[1]) ps2_data[1] = f1[i];
            repeat (4) cyc_step();
            ps2_clk  = ps2_clk & ~mask;
            fall_cyc = cyc;
            if (glitch) begin
                repeat (6) cyc_step();
                ps2_clk = ps2_clk | mask;
                cyc_step();
                ps2_clk = ps2_clk & ~mask;
                cyc_step();
            end else begin
                repeat (8) cyc_step();
            end
            ps2_clk = ps2_clk | mask;
            if (glitch) begin
                cyc_step();
                ps2_clk = ps2_clk & ~mask;
                cyc_step();
                ps2_clk = ps2_clk | mask;
                repeat (2) cyc_step();
            end else begin
                repeat (4) cyc_step();
            end
        end
        ps2_data = ps2_data | mask;
    endtask

    task automatic expect_entry(input string tag, input int ch, input int st,
                                input int d, input int lim);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_chan"}, 32'(out_chan), 32'(ch));
        chk({tag, "_status"}, 32'(out_status), 32'(st));
        chk({tag, "_data"}, 32'(out_data), 32'(d));
        out_ready = 1'b1;
        cyc_step();
        out_ready = 1'b0;
    endtask

    initial begin
        ps2_clk     = 2'b11;
        ps2_data    = 2'b11;
        out_ready   = 1'b0;
        overrun_clr = 2'b00;
        reset       = 1'b1;
        repeat (3) cyc_step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_status", 32'(out_status), 0);
        chk("rst_chan", 32'(out_chan), 0);

        // 2 sync + 4 filter cycles to the edge cycle, then E+2.
        send(2'b01, frame(8'h1C, 1'b0, 1'b1), 11'h7FF, 11, 1'b0);
        chk("latency", 32'(valid_cyc - fall_cyc), 32'd8);
        expect_entry("ok1c", 0, 0, 'h1C, 50);

        send(2'b10, 11'h7FF, frame(8'hF0, 1'b1, 1'b1), 11, 1'b0);
        expect_entry("par", 1, 1, 'hF0, 50);
        send(2'b10, 11'h7FF, frame(8'h3C, 1'b0, 1'b0), 11, 1'b0);
        expect_entry("stop", 1, 2, 'h3C, 50);

        send(2'b11, frame(8'h11, 1'b0, 1'b1), frame(8'h22, 1'b0, 1'b1),
             11, 1'b0);
        expect_entry("rr_a0", 0, 0, 'h11, 50);
        expect_entry("rr_a1", 1, 0, 'h22, 50);
        send(2'b01, frame(8'h33, 1'b0, 1'b1), 11'h7FF, 11, 1'b0);
        expect_entry("rr_mid", 0, 0, 'h33, 50);
        send(2'b11, frame(8'h44, 1'b0, 1'b1), frame(8'h55, 1'b0, 1'b1),
             11, 1'b0);
        expect_entry("rr_b1", 1, 0, 'h55, 50);
        expect_entry("rr_b0", 0, 0, 'h44, 50);

        send(2'b01, frame(8'h0F, 1'b0, 1'b1), 11'h7FF, 5, 1'b0);
        repeat (1900) @(negedge clk);
        chk("tmo_early", 32'(out_valid), 0);
        expect_entry("tmo", 0, 3, 'h00, 400);
        send(2'b01, frame(8'hA7, 1'b0, 1'b1), 11'h7FF, 11, 1'b0);
        expect_entry("after_tmo", 0, 0, 'hA7, 50);

        for (int i = 0; i < 10; i++) begin
            send(2'b01, frame(8'(8'h10 + i), 1'b0, 1'b1), 11'h7FF, 11, 1'b0);
        end
        repeat (4) @(negedge clk);
        chk("full_level", 32'(fifo_level), 8);
        chk("full_head", 32'(out_data), 'h10);
        chk("ovr_set", 32'(overrun), 32'b01);
        cyc_step();
        overrun_clr = 2'b01;
        cyc_step();
        overrun_clr = 2'b00;
        @(negedge clk);
        chk("ovr_clr", 32'(overrun), 0);
        for (int i = 0; i < 9; i++) begin
            expect_entry("drain", 0, 0, 'h10 + i, 20);
        end
        @(negedge clk);
        chk("drain_level", 32'(fifo_level), 0);

        send(2'b01, frame(8'hA5, 1'b0, 1'b1), 11'h7FF, 11, 1'b1);
        expect_entry("glitch", 0, 0, 'hA5, 50);
        repeat (40) @(negedge clk);
        chk("glitch_extra", 32'(fifo_level), 0);

        send(2'b10, 11'h7FF, frame(8'h66, 1'b0, 1'b1), 11, 1'b0);
        repeat (10) @(negedge clk);
        chk("pre_rst_level", 32'(fifo_level), 1);
        send(2'b01, frame(8'h77, 1'b0, 1'b1), 11'h7FF, 5, 1'b0);
        reset = 1'b1;
        repeat (2) cyc_step();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        chk("mid_rst_status", 32'(out_status), 0);
        chk("mid_rst_chan", 32'(out_chan), 0);
        chk("mid_rst_ovr", 32'(overrun), 0);
        repeat (2200) @(negedge clk);
        chk("mid_rst_quiet", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
